// File: rtl/riscv5_arith_pkg.sv
// Shared arithmetic definitions for the RISC5 execute-stage multiplier and divider.
package riscv5_arith_pkg;

    localparam int W         = 32;
    localparam int MUL_STEPS = W + 1;
    localparam int SW        = 6;

    typedef logic [SW-1:0] step_t;

    // Extend a W-bit operand to W+1 bits: sign-extend when sgn=1, zero-extend otherwise.
    function automatic logic [W:0] e(input logic [W-1:0] v, input logic sgn);
        return {sgn & v[W-1], v};
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Run/stall handshake and operand/product bus between the CPU and the multiplier.
interface seq_multiplier_if #(
    parameter int W = 32
);
    logic           run;
    logic           u;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           stall;
    logic [2*W-1:0] z;

    modport master (output run, output u, output x, output y, input stall, input z);
    modport slave  (input run, input u, input x, input y, output stall, output z);
endinterface

// File: rtl/mul_step.sv
// One shift-add iteration: conditionally add (or subtract on the signed last step) y into the
// upper half of P, then shift the whole register right by one.
module mul_step #(
    parameter int W = 32
) (
    input  logic [2*W-1:0] p,
    input  logic [W-1:0]   y,
    input  logic           u,
    input  logic           last_step,
    output logic [2*W-1:0] p_next
);
    logic [W-1:0] a;
    logic [W:0]   hi_ext;
    logic [W:0]   a_ext;
    logic [W:0]   w1;

    // Addend select, operand extension and add/subtract; the multiplier sign bit has negative weight.
    always_comb begin
        a      = p[0] ? y : '0;
        hi_ext = {u & p[2*W-1], p[2*W-1:W]};
        a_ext  = {u & a[W-1], a};
        if (last_step && u) begin
            w1 = hi_ext - a_ext;
        end else begin
            w1 = hi_ext + a_ext;
        end
        p_next = {w1, p[W-1:1]};
    end
endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: full 2W-bit signed/unsigned product, one multiplier bit per cycle,
// using the same run/stall handshake as the divider.
module seq_multiplier
    import riscv5_arith_pkg::*;
#(
    parameter int W  = riscv5_arith_pkg::W,
    parameter int SW = riscv5_arith_pkg::SW
) (
    input  logic             clk,
    input  logic             rst,
    seq_multiplier_if.slave  bus
);
    localparam logic [SW-1:0] S_LAST = SW'(W + 1);
    localparam logic [SW-1:0] S_SIGN = SW'(W);

    logic [SW-1:0]  s;
    logic [2*W-1:0] p;
    logic [2*W-1:0] p_step;

    mul_step #(.W(W)) u_step (
        .p         (p),
        .y         (bus.y),
        .u         (bus.u),
        .last_step (s == S_SIGN),
        .p_next    (p_step)
    );

    // Handshake outputs: stall until the counter reaches the done step.
    always_comb begin
        bus.stall = bus.run & (s != S_LAST);
        bus.z     = p;
    end

    // Step counter: abort on run=0, wrap to a fresh load after the done step.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s <= '0;
        end else if (!bus.run || s == S_LAST) begin
            s <= '0;
        end else begin
            s <= s + SW'(1);
        end
    end

    // Product register: load x at step 0, iterate through step W, hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            p <= '0;
        end else if (bus.run) begin
            if (s == '0) begin
                p <= {{W{1'b0}}, bus.x};
            end else if (s != S_LAST) begin
                p <= p_step;
            end
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed-vector bench for seq_multiplier: latency, signed/unsigned products, back-to-back,
// abort and mid-operation reset.
module tb_seq_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    seq_multiplier_if #(.W(32)) ifc ();

    seq_multiplier #(.W(32), .SW(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    // Start an operation at a falling edge; that cycle is cycle 0 of the operation.
    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic u);
        @(negedge clk);
        ifc.x = x;
        ifc.y = y;
        ifc.u = u;
        ifc.run = 1'b1;
        #1;
    endtask

    // Count cycles while stall is high, bounded at 100.
    task automatic wait_done(output int n);
        n = 0;
        while (ifc.stall === 1'b1 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        ifc.run = 1'b0;
        ifc.u = 1'b0;
        ifc.x = '0;
        ifc.y = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (ifc.z !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_z: got %h expected %h", ifc.z, 64'd0);
        end
        vectors++;
        if (ifc.stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stall_idle: got %b expected 0", ifc.stall);
        end
        ifc.run = 1'b1;
        #1;
        vectors++;
        if (ifc.stall !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_stall_run: got %b expected 1", ifc.stall);
        end
        @(negedge clk);
        ifc.run = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        int n;
        start_op(32'd7, 32'd6, 1'b0);
        wait_done(n);
        vectors++;
        if (n !== 33) begin
            miscompares++;
            $display("FAIL latency_cycles: got %0d expected 33", n);
        end
        vectors++;
        if (ifc.z !== 64'h0000_0000_0000_002A) begin
            miscompares++;
            $display("FAIL latency_z: got %h expected %h", ifc.z, 64'h2A);
        end
        ifc.run = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (ifc.z !== 64'h0000_0000_0000_002A || ifc.stall !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_hold: got z=%h stall=%b expected z=%h stall=0", ifc.z, ifc.stall, 64'h2A);
        end
    endtask

    task automatic test_products();
        logic [31:0] tx [6];
        logic [31:0] ty [6];
        logic        tu [6];
        logic [63:0] tz [6];
        int n;
        tx[0] = 32'hFFFF_FFFD; ty[0] = 32'd5;          tu[0] = 1'b1; tz[0] = 64'hFFFF_FFFF_FFFF_FFF1;
        tx[1] = 32'hFFFF_FFFD; ty[1] = 32'd5;          tu[1] = 1'b0; tz[1] = 64'h0000_0004_FFFF_FFF1;
        tx[2] = 32'hFFFF_FFFF; ty[2] = 32'hFFFF_FFFF;  tu[2] = 1'b0; tz[2] = 64'hFFFF_FFFE_0000_0001;
        tx[3] = 32'hFFFF_FFFF; ty[3] = 32'hFFFF_FFFF;  tu[3] = 1'b1; tz[3] = 64'h0000_0000_0000_0001;
        tx[4] = 32'h8000_0000; ty[4] = 32'h8000_0000;  tu[4] = 1'b1; tz[4] = 64'h4000_0000_0000_0000;
        tx[5] = 32'd5;         ty[5] = 32'hFFFF_FFFD;  tu[5] = 1'b1; tz[5] = 64'hFFFF_FFFF_FFFF_FFF1;
        for (int i = 0; i < 6; i++) begin
            start_op(tx[i], ty[i], tu[i]);
            wait_done(n);
            vectors++;
            if (n !== 33 || ifc.z !== tz[i]) begin
                miscompares++;
                $display("FAIL product_%0d: got z=%h cycles=%0d expected z=%h cycles=33", i, ifc.z, n, tz[i]);
            end
            ifc.run = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        start_op(32'd3, 32'd4, 1'b0);
        wait_done(n);
        vectors++;
        if (n !== 33 || ifc.z !== 64'd12) begin
            miscompares++;
            $display("FAIL b2b_first: got z=%h cycles=%0d expected z=%h cycles=33", ifc.z, n, 64'd12);
        end
        ifc.x = 32'h0001_0000;
        ifc.y = 32'h0001_0000;
        @(negedge clk);
        #1;
        vectors++;
        if (ifc.stall !== 1'b1 || dut.s !== 6'd0) begin
            miscompares++;
            $display("FAIL b2b_restart: got stall=%b s=%0d expected stall=1 s=0", ifc.stall, dut.s);
        end
        wait_done(n);
        vectors++;
        if (n !== 33 || ifc.z !== 64'h0000_0001_0000_0000) begin
            miscompares++;
            $display("FAIL b2b_second: got z=%h cycles=%0d expected z=%h cycles=33", ifc.z, n, 64'h1_0000_0000);
        end
        ifc.run = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        int n;
        start_op(32'd9, 32'd9, 1'b0);
        repeat (10) @(negedge clk);
        #1;
        vectors++;
        if (dut.s !== 6'd10) begin
            miscompares++;
            $display("FAIL abort_step: got s=%0d expected 10", dut.s);
        end
        ifc.run = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (dut.s !== 6'd0 || ifc.stall !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_clear: got s=%0d stall=%b expected s=0 stall=0", dut.s, ifc.stall);
        end
        start_op(32'd7, 32'd6, 1'b0);
        wait_done(n);
        vectors++;
        if (n !== 33 || ifc.z !== 64'd42) begin
            miscompares++;
            $display("FAIL abort_rerun: got z=%h cycles=%0d expected z=%h cycles=33", ifc.z, n, 64'd42);
        end
        ifc.run = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        int n;
        start_op(32'd7, 32'd6, 1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (ifc.z !== 64'd0 || ifc.stall !== 1'b1 || dut.s !== 6'd0) begin
            miscompares++;
            $display("FAIL midop_reset: got z=%h stall=%b s=%0d expected z=0 stall=1 s=0", ifc.z, ifc.stall, dut.s);
        end
        wait_done(n);
        vectors++;
        if (n !== 33 || ifc.z !== 64'd42) begin
            miscompares++;
            $display("FAIL midop_restart: got z=%h cycles=%0d expected z=%h cycles=33", ifc.z, n, 64'd42);
        end
        ifc.run = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_products();
        test_back_to_back();
        test_abort();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
